// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the piso_tx serialiser.
package piso_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 5;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load shift register; shifts toward the output end selected by LSB_FIRST.
module piso_shift
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift so a back-to-back reload never sees a stale shift.
    always_comb begin
        shreg_d = shreg_q;
        if (ld) begin
            shreg_d = d;
        end else if (sh) begin
            if (LSB_FIRST) begin
                shreg_d = {fill, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], fill};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q = shreg_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: handshake, bit counter and framing around piso_shift.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic        IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             frame,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            shift_en;
    logic [WIDTH-1:0] sr;

    // cnt counts bits still to follow the one on dout; cnt==0 marks the last bit.
    always_comb begin
        ready    = (state_q == IDLE) || (cnt_q == '0);
        accept   = load && ready;
        shift_en = (state_q == SHIFT) && (cnt_q != '0);
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CNT_LAST;
        end else if (shift_en) begin
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .ld   (accept),
        .sh   (shift_en),
        .d    (din),
        .fill (IDLE_LVL),
        .q    (sr)
    );

    always_comb begin
        frame = (state_q == SHIFT);
        done  = frame && (cnt_q == '0);
        if (!frame) begin
            dout = IDLE_LVL;
        end else if (LSB_FIRST) begin
            dout = sr[0];
        end else begin
            dout = sr[WIDTH-1];
        end
    end

    assign q = sr;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: LSB-first and MSB-first instances share stimulus.
module tb_piso_tx;

    localparam int   W    = 5;
    localparam logic IDLV = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load;
    logic         ready, dout, frame, done;
    logic [W-1:0] q;
    logic         ready_m, dout_m, frame_m, done_m;
    logic [W-1:0] q_m;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LVL(IDLV)) dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready),
        .dout(dout), .frame(frame), .done(done), .q(q)
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LVL(IDLV)) dut_m (
        .clk(clk), .rst(rst), .din(din), .load(load), .ready(ready_m),
        .dout(dout_m), .frame(frame_m), .done(done_m), .q(q_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         bl;
        logic         bm;
        logic         last;
        logic         first;
        logic [W-1:0] word;
    } exp_t;

    exp_t         sb[$];
    int           busy_left = 0;
    int           n_checks  = 0;
    int           n_fail    = 0;
    logic [W-1:0] lb        = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: an accepted word expands into W expected bits.
    task automatic cyc(input logic l, input logic [W-1:0] d, output bit acc);
        exp_t e;
        acc  = l && (busy_left <= 1);
        load = l;
        din  = d;
        @(posedge clk);
        #1;
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                e.bl    = d[i];
                e.bm    = d[W-1-i];
                e.last  = (i == W - 1);
                e.first = (i == 0);
                e.word  = d;
                sb.push_back(e);
            end
            busy_left = W;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("ready", ready, busy_left <= 1);
            check("ready_m", ready_m, busy_left <= 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("frame", frame, 1);
                check("frame_m", frame_m, 1);
                check("dout", dout, e.bl);
                check("dout_m", dout_m, e.bm);
                check("done", done, e.last);
                check("done_m", done_m, e.last);
                if (e.first) check("q_load", q, e.word);
                lb = {dout, lb[W-1:1]};
                if (e.last) check("loopback", lb, e.word);
            end else begin
                check("idle_frame", frame, 0);
                check("idle_frame_m", frame_m, 0);
                check("idle_done", done, 0);
                check("idle_dout", dout, IDLV);
                check("idle_dout_m", dout_m, IDLV);
            end
        end
    end

    initial begin
        bit a;
        int acc_words;
        rst  = 1'b1;
        load = 1'b0;
        din  = '0;
        #3;
        check("rst_q", q, 0);
        check("rst_dout", dout, IDLV);
        check("rst_frame", frame, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        @(posedge clk);
        #3 rst = 1'b0;

        // single word, accepted on the first edge after reset release
        cyc(1'b1, 5'b10110, a);
        check("first_accept", a, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, W'($urandom), a);

        // back-to-back words, second load while done is high
        cyc(1'b1, 5'b00011, a);
        for (int i = 0; i < 4; i++) cyc(1'b0, W'($urandom), a);
        cyc(1'b1, 5'b11100, a);
        check("b2b_accept", a, 1);
        for (int i = 0; i < 6; i++) cyc(1'b0, W'($urandom), a);

        // load while busy is dropped
        cyc(1'b1, 5'b00000, a);
        cyc(1'b1, 5'b11111, a);
        for (int i = 0; i < 6; i++) cyc(1'b0, W'($urandom), a);

        // asynchronous reset in the middle of a frame
        cyc(1'b1, 5'b11011, a);
        cyc(1'b0, 5'b00000, a);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dout", dout, IDLV);
        check("mid_rst_dout_m", dout_m, IDLV);
        check("mid_rst_frame", frame, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_q", q, 0);
        sb.delete();
        busy_left = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, W'($urandom), a);

        // random traffic
        acc_words = 0;
        for (int c = 0; c < 5000 && acc_words < 100; c++) begin
            cyc($urandom_range(0, 3) != 0, W'($urandom), a);
            if (a) acc_words++;
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, W'($urandom), a);
        check("random_words", acc_words >= 100, 1);
        check("drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
